// File: rtl/dma_pcie_mi_par_ram.sv
// dma_pcie_mi_par_ram
//   Simple-dual-port, parity-protected RAM for the DMA/PCIe queue-context and
//   descriptor buffers. Each entry stores DW data bits plus one even-parity
//   bit per byte lane. Reads come back after RD_LAT cycles and are checked
//   lane by lane. A check that finds one bad lane raises rsbe. A check that
//   finds two or more bad lanes raises rdbe. Both events have saturating
//   counters. A one-shot injector corrupts lane-0 parity of the next write.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   wen/wadr        write strobe and address
//   wdat/wpar       write data and per-lane parity
//   ren/radr        read strobe and address
//   rvld            read result valid; rdat/rpar hold while low
//   rdat/rpar       read data and stored parity
//   rsbe/rdbe       single / multi lane parity mismatch on the current result
//   inj_par_err     arms corruption of lane-0 parity on the next write
//   err_clr         synchronous clear of both error counters
//   sbe_cnt/dbe_cnt saturating error event counters
module dma_pcie_mi_par_ram #(
  parameter int DW        = 16,
  parameter int AW        = 12,
  parameter int RD_LAT    = 1,
  parameter int WR_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      wadr,
  input  logic               wen,
  input  logic [DW/8-1:0]    wpar,
  input  logic [DW-1:0]      wdat,
  input  logic               ren,
  input  logic [AW-1:0]      radr,
  output logic               rvld,
  output logic [DW/8-1:0]    rpar,
  output logic [DW-1:0]      rdat,
  output logic               rsbe,
  output logic               rdbe,
  input  logic               inj_par_err,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   sbe_cnt,
  output logic [CNT_W-1:0]   dbe_cnt
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;
  localparam int WW    = DW + NB;

  if ((DW % 8) != 0 || DW < 8 || RD_LAT < 1 || RD_LAT > 3) begin : g_bad_param
    $error("dma_pcie_mi_par_ram: DW must be a multiple of 8 and RD_LAT must be 1..3");
  end

  // Storage array. It has no reset, so its contents survive rst.
  logic [WW-1:0]     mem [DEPTH];

  logic              arm_q, arm_d;
  logic              inj_now;
  logic [NB-1:0]     wpar_eff;
  logic              collide;
  logic [WW-1:0]     rd_word;

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [WW-1:0]     word_q [RD_LAT];
  logic [WW-1:0]     word_d [RD_LAT];

  logic [NB-1:0]     mm;
  logic              multi;
  logic              single;
  logic [CNT_W-1:0]  sbe_cnt_q, sbe_cnt_d;
  logic [CNT_W-1:0]  dbe_cnt_q, dbe_cnt_d;

  // The injection arm stays set until a write consumes it. A pulse in the
  // same cycle as a write hits that write directly. The read pipeline keeps
  // each stage's word until a new valid word arrives, so rdat/rpar hold
  // their last value between reads.
  always_comb begin
    inj_now  = wen & (arm_q | inj_par_err);
    wpar_eff = wpar ^ NB'(inj_now);
    arm_d    = wen ? 1'b0 : (arm_q | inj_par_err);

    collide  = (WR_BYPASS != 0) && wen && (wadr == radr);
    rd_word  = collide ? {wpar_eff, wdat} : mem[radr];

    vld_d[0]  = ren;
    word_d[0] = ren ? rd_word : word_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      word_d[i] = vld_q[i-1] ? word_q[i-1] : word_q[i];
    end
  end

  assign rvld = vld_q[RD_LAT-1];
  assign rdat = word_q[RD_LAT-1][DW-1:0];
  assign rpar = word_q[RD_LAT-1][WW-1:DW];

  // Lane mismatch vector. mm & (mm-1) clears the lowest set bit, so any bit
  // left over means at least two lanes disagree.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      mm[i] = rpar[i] ^ (^rdat[8*i +: 8]);
    end
    multi  = |(mm & (mm - NB'(1)));
    single = (mm != '0) && !multi;
  end

  assign rsbe = rvld & single;
  assign rdbe = rvld & multi;

  // Saturating counters. A clear takes priority over an increment in the
  // same cycle.
  always_comb begin
    sbe_cnt_d = sbe_cnt_q;
    dbe_cnt_d = dbe_cnt_q;
    if (err_clr) begin
      sbe_cnt_d = '0;
      dbe_cnt_d = '0;
    end else begin
      if (rsbe && (sbe_cnt_q != '1)) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
      if (rdbe && (dbe_cnt_q != '1)) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
    end
  end

  assign sbe_cnt = sbe_cnt_q;
  assign dbe_cnt = dbe_cnt_q;

  // Array write. Reads of the same address in this cycle see the old
  // contents unless the bypass path above selects the new word.
  always_ff @(posedge clk) begin
    if (wen) mem[wadr] <= {wpar_eff, wdat};
  end

  // Control and read pipeline registers. Reset drops any reads in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q     <= 1'b0;
      vld_q     <= '0;
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
      for (int i = 0; i < RD_LAT; i++) word_q[i] <= '0;
    end else begin
      arm_q     <= arm_d;
      vld_q     <= vld_d;
      sbe_cnt_q <= sbe_cnt_d;
      dbe_cnt_q <= dbe_cnt_d;
      for (int i = 0; i < RD_LAT; i++) word_q[i] <= word_d[i];
    end
  end

endmodule

// File: tb/tb_dma_pcie_mi_par_ram.sv
// tb_dma_pcie_mi_par_ram
//   Drives two instances with identical stimulus. Instance 0 uses the
//   defaults: RD_LAT=1, bypass on, 16-bit counters. Instance 1 uses RD_LAT=3,
//   bypass off, 2-bit counters. Expected outputs come from a transaction-level
//   model: a flat memory array, a queue of pending reads tagged with their
//   due cycle, and integer error counters.
module tb_dma_pcie_mi_par_ram;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NB = 2;
  localparam int WW = DW + NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, wen, ren, inj_par_err, err_clr;
  logic [AW-1:0]   wadr, radr;
  logic [NB-1:0]   wpar;
  logic [DW-1:0]   wdat;

  logic            rvld [2];
  logic [NB-1:0]   rpar [2];
  logic [DW-1:0]   rdat [2];
  logic            rsbe [2];
  logic            rdbe [2];
  logic [15:0]     sbe_cnt_a, dbe_cnt_a;
  logic [1:0]      sbe_cnt_b, dbe_cnt_b;

  dma_pcie_mi_par_ram #(.DW(DW), .AW(AW), .RD_LAT(1), .WR_BYPASS(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wpar(wpar), .wdat(wdat),
    .ren(ren), .radr(radr), .rvld(rvld[0]), .rpar(rpar[0]), .rdat(rdat[0]),
    .rsbe(rsbe[0]), .rdbe(rdbe[0]), .inj_par_err(inj_par_err), .err_clr(err_clr),
    .sbe_cnt(sbe_cnt_a), .dbe_cnt(dbe_cnt_a)
  );

  dma_pcie_mi_par_ram #(.DW(DW), .AW(AW), .RD_LAT(3), .WR_BYPASS(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wpar(wpar), .wdat(wdat),
    .ren(ren), .radr(radr), .rvld(rvld[1]), .rpar(rpar[1]), .rdat(rdat[1]),
    .rsbe(rsbe[1]), .rdbe(rdbe[1]), .inj_par_err(inj_par_err), .err_clr(err_clr),
    .sbe_cnt(sbe_cnt_b), .dbe_cnt(dbe_cnt_b)
  );

  // Everything observable from one instance, packed for a single compare.
  logic [52:0] obs   [2];
  logic [52:0] exp_v [2];
  assign obs[0] = {rvld[0], rpar[0], rdat[0], rsbe[0], rdbe[0], sbe_cnt_a, dbe_cnt_a};
  assign obs[1] = {rvld[1], rpar[1], rdat[1], rsbe[1], rdbe[1], 14'b0, sbe_cnt_b, 14'b0, dbe_cnt_b};

  typedef struct {
    int          d;
    int          due;
    logic [WW-1:0] word;
  } rd_t;

  int            lat  [2] = '{1, 3};
  bit            byp  [2] = '{1'b1, 1'b0};
  int            cmax [2] = '{65535, 3};
  logic [WW-1:0] mmem [0:4095];
  rd_t           pend [$];
  int            scnt [2];
  int            dcnt [2];
  bit            prev_sbe [2];
  bit            prev_dbe [2];
  logic [WW-1:0] last_word [2];
  bit            arm;
  int            cyc;
  int            tests;
  int            fails;

  function automatic int bad_lanes(input logic [WW-1:0] w);
    int n = 0;
    for (int i = 0; i < NB; i++) if (w[DW+i] !== ^w[8*i +: 8]) n++;
    return n;
  endfunction

  function automatic logic [NB-1:0] good_par(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  task automatic idle();
    wen = 1'b0; ren = 1'b0; inj_par_err = 1'b0; err_clr = 1'b0;
  endtask

  task automatic model_reset();
    pend.delete();
    arm = 1'b0;
    for (int d = 0; d < 2; d++) begin
      scnt[d] = 0; dcnt[d] = 0; prev_sbe[d] = 1'b0; prev_dbe[d] = 1'b0; last_word[d] = '0;
    end
  endtask

  // Advance one clock and update the model's expected outputs.
  task automatic tick();
    logic [NB-1:0] eff;
    logic          inj;
    rd_t           e;
    int            idx;
    int            n;
    bit            ev, es, ed;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (err_clr) begin
          scnt[d] = 0; dcnt[d] = 0;
        end else begin
          if (prev_sbe[d] && scnt[d] < cmax[d]) scnt[d]++;
          if (prev_dbe[d] && dcnt[d] < cmax[d]) dcnt[d]++;
        end
      end
      inj = wen && (arm || inj_par_err);
      eff = wpar ^ {1'b0, inj};
      arm = wen ? 1'b0 : (arm || inj_par_err);
      if (ren) begin
        for (int d = 0; d < 2; d++) begin
          e.d    = d;
          e.due  = cyc + lat[d] - 1;
          e.word = (byp[d] && wen && wadr == radr) ? {eff, wdat} : mmem[radr];
          pend.push_back(e);
        end
      end
      if (wen) mmem[wadr] = {eff, wdat};
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      idx = -1;
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].d == d) begin idx = i; break; end
      end
      ev = 1'b0; es = 1'b0; ed = 1'b0;
      if (idx >= 0 && pend[idx].due == cyc) begin
        ev = 1'b1;
        last_word[d] = pend[idx].word;
        pend.delete(idx);
        n  = bad_lanes(last_word[d]);
        es = (n == 1);
        ed = (n >= 2);
      end
      prev_sbe[d] = es;
      prev_dbe[d] = ed;
      exp_v[d] = {ev, last_word[d], es, ed, 16'(scnt[d]), 16'(dcnt[d])};
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL reset_state dut%0d got %h expected %h", d, obs[d], exp_v[d]);
        end
      end
    end
    tests++;
    if (rvld[0] !== 1'b0 || rdat[0] !== 16'h0 || sbe_cnt_a !== 16'h0) begin
      fails++; $display("[TB] FAIL reset_const got rvld=%b rdat=%h cnt=%h expected 0", rvld[0], rdat[0], sbe_cnt_a);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c < 6; c++) begin
      idle();
      if (c == 0) begin wen = 1'b1; wadr = 12'h010; wdat = 16'hA5C3; wpar = 2'b00; end
      if (c == 1) begin ren = 1'b1; radr = 12'h010; end
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL basic dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
      if (c == 1) begin
        tests++;
        if ({rvld[0], rdat[0], rsbe[0], rdbe[0]} !== {1'b1, 16'hA5C3, 2'b00}) begin
          fails++; $display("[TB] FAIL basic_lat1 got %b/%h/%b%b expected 1/a5c3/00", rvld[0], rdat[0], rsbe[0], rdbe[0]);
        end
      end
      if (c == 3) begin
        tests++;
        if ({rvld[1], rdat[1]} !== {1'b1, 16'hA5C3}) begin
          fails++; $display("[TB] FAIL basic_lat3 got %b/%h expected 1/a5c3", rvld[1], rdat[1]);
        end
      end
    end
  endtask

  task automatic test_inject();
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0) inj_par_err = 1'b1;
      if (c == 1) begin inj_par_err = 1'b1; wen = 1'b1; wadr = 12'h020; wdat = 16'h00FF; wpar = 2'b00; end
      if (c == 2) begin ren = 1'b1; radr = 12'h020; end
      if (c == 3) begin wen = 1'b1; wadr = 12'h021; wdat = 16'h00FF; wpar = 2'b00; end
      if (c == 4) begin ren = 1'b1; radr = 12'h021; end
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL inject dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
      if (c == 2) begin
        tests++;
        if ({rpar[0], rsbe[0]} !== {2'b01, 1'b1}) begin
          fails++; $display("[TB] FAIL inject_par got %b/%b expected 01/1", rpar[0], rsbe[0]);
        end
      end
      if (c == 3) begin
        tests++;
        if (sbe_cnt_a !== 16'd1) begin
          fails++; $display("[TB] FAIL inject_cnt got %0d expected 1", sbe_cnt_a);
        end
      end
      if (c == 4) begin
        tests++;
        if ({rpar[0], rsbe[0]} !== {2'b00, 1'b0}) begin
          fails++; $display("[TB] FAIL inject_oneshot got %b/%b expected 00/0", rpar[0], rsbe[0]);
        end
      end
    end
  endtask

  task automatic test_double();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c == 0) begin wen = 1'b1; wadr = 12'h040; wdat = 16'h1234; wpar = 2'b10; end
      if (c == 1) begin wen = 1'b1; wadr = 12'h041; wdat = 16'h1234; wpar = 2'b11; end
      if (c == 2) begin ren = 1'b1; radr = 12'h040; end
      if (c == 3) begin ren = 1'b1; radr = 12'h041; end
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL double dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
      if (c == 2) begin
        tests++;
        if ({rdbe[0], rsbe[0]} !== 2'b10) begin
          fails++; $display("[TB] FAIL double_flags got dbe=%b sbe=%b expected 1/0", rdbe[0], rsbe[0]);
        end
      end
      if (c == 3) begin
        tests++;
        if (dbe_cnt_a !== 16'd1) begin
          fails++; $display("[TB] FAIL double_cnt got %0d expected 1", dbe_cnt_a);
        end
      end
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) begin wen = 1'b1; wadr = 12'h030; wdat = 16'h1111; wpar = 2'b00; end
      if (c == 1) begin
        wen = 1'b1; wadr = 12'h030; wdat = 16'h2222; wpar = 2'b00;
        ren = 1'b1; radr = 12'h030;
      end
      if (c == 2) begin ren = 1'b1; radr = 12'h030; end
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL collision dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
      if (c == 1) begin
        tests++;
        if (rdat[0] !== 16'h2222) begin
          fails++; $display("[TB] FAIL collision_bypass got %h expected 2222", rdat[0]);
        end
      end
      if (c == 3) begin
        tests++;
        if (rdat[1] !== 16'h1111) begin
          fails++; $display("[TB] FAIL collision_nobypass got %h expected 1111", rdat[1]);
        end
      end
      if (c == 4) begin
        tests++;
        if (rdat[1] !== 16'h2222) begin
          fails++; $display("[TB] FAIL collision_later got %h expected 2222", rdat[1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    for (int c = 0; c < 21; c++) begin
      idle();
      if (c < 8) begin
        wen = 1'b1; wadr = 12'(c); wdat = 16'($urandom); wpar = good_par(wdat);
      end else if (c < 16) begin
        ren = 1'b1; radr = 12'(c - 8);
      end
      tick();
      if (rvld[1] === 1'b1) vcnt++;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL burst dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
    end
    tests++;
    if (vcnt != 8) begin
      fails++; $display("[TB] FAIL burst_vld_count got %0d expected 8", vcnt);
    end
  endtask

  task automatic test_reset_midread();
    int vcnt = 0;
    for (int c = 0; c < 18; c++) begin
      idle();
      if (c < 2) begin ren = 1'b1; radr = 12'(c); end
      if (c == 2) begin rst = 1'b1; model_reset(); end
      if (c == 3) rst = 1'b0;
      if (c >= 8 && c < 16) begin ren = 1'b1; radr = 12'(c - 8); end
      tick();
      if (c >= 2 && c < 8 && rvld[1] === 1'b1) vcnt++;
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL midreset dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
    end
    tests++;
    if (vcnt != 0 || sbe_cnt_a !== 16'd0 || dbe_cnt_b !== 2'd0) begin
      fails++; $display("[TB] FAIL midreset_drop got vld=%0d cnt=%0d/%0d expected 0/0/0", vcnt, sbe_cnt_a, dbe_cnt_b);
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 20; c++) begin
      idle();
      if (c == 0) begin
        err_clr = 1'b1; wen = 1'b1; wadr = 12'h050; wdat = 16'h00FF; wpar = 2'b01;
      end
      if ((c >= 1 && c <= 5) || (c >= 9 && c <= 14)) begin ren = 1'b1; radr = 12'h050; end
      if (c == 12) err_clr = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL saturate dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
      if (c == 8) begin
        tests++;
        if (sbe_cnt_b !== 2'd3 || sbe_cnt_a !== 16'd5) begin
          fails++; $display("[TB] FAIL saturate_hold got %0d/%0d expected 3/5", sbe_cnt_b, sbe_cnt_a);
        end
      end
      if (c == 12) begin
        tests++;
        if (sbe_cnt_b !== 2'd0 || sbe_cnt_a !== 16'd0) begin
          fails++; $display("[TB] FAIL clear_wins got %0d/%0d expected 0/0", sbe_cnt_b, sbe_cnt_a);
        end
      end
    end
  endtask

  // Random traffic on a 16-entry window that wraps past the top address.
  task automatic test_random();
    for (int c = 0; c < 330; c++) begin
      idle();
      if (c < 16) begin
        wen = 1'b1; wadr = 12'hFF8 + 12'(c); wdat = 16'($urandom); wpar = good_par(wdat);
      end else if (c < 320) begin
        wen  = ($urandom_range(0, 1) == 1);
        wadr = 12'hFF8 + 12'($urandom_range(0, 15));
        wdat = 16'($urandom);
        wpar = good_par(wdat);
        if ($urandom_range(0, 3) == 0) wpar = wpar ^ 2'($urandom_range(1, 3));
        ren  = ($urandom_range(0, 9) < 6);
        radr = 12'hFF8 + 12'($urandom_range(0, 15));
        inj_par_err = ($urandom_range(0, 19) == 0);
        err_clr     = ($urandom_range(0, 29) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        tests++;
        if (obs[d] !== exp_v[d]) begin
          fails++; $display("[TB] FAIL random dut%0d cyc%0d got %h expected %h", d, c, obs[d], exp_v[d]);
        end
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    wadr = '0; radr = '0; wdat = '0; wpar = '0;
    idle();
    test_reset();
    test_basic();
    test_inject();
    test_double();
    test_collision();
    test_back_to_back();
    test_reset_midread();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
